uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  - Shares one UART Transmitter among NREQ byte-stream requesters (echo path, status reporter, debug dump).
//  - Round-robin grant per byte; drives Transmitter tx_start/data_in and waits for its tx_done pulse.
//  - Sits between requester logic and the Transmitter instance; baud tick stays inside the Transmitter.
// PARAMETERS
//  - NREQ      4   number of requesters (2..8)
//  - DBITS     8   data bits per byte, matches Transmitter DBITS
//  - MAX_BURST 4   max consecutive bytes per grant (used only with UART_TX_ARB_BURST_EN)
// PORTS
//  - clk        in   1           system clock
//  - reset      in   1           asynchronous, active-high reset
//  - req        in   NREQ        level request per requester; data must hold while req=1 and ack not yet seen
//  - req_data   in   NREQ*DBITS  byte of requester i on bits [i*DBITS +: DBITS]
//  - ack        out  NREQ        one-cycle pulse: byte of requester i latched
//  - tx_start   out  1           one-cycle start pulse to Transmitter
//  - tx_data    out  DBITS       byte to Transmitter, stable from tx_start until tx_done
//  - tx_done    in   1           one-cycle completion pulse from Transmitter
//  - busy       out  1           1 from the grant cycle until tx_done is consumed
//  - grant_id   out  clog2(NREQ) index of current/last grant
// BEHAVIOUR
//  - All outputs registered. Reset values: ack=0, tx_start=0, tx_data=0, busy=0, grant_id=0.
//  - Internal rr pointer resets to NREQ-1, so requester 0 wins first.
//  - FSM states: IDLE, START, WAIT_DONE.
//  - IDLE: if |req, pick the first requester at or after (ptr+1) mod NREQ; latch its byte into tx_data.
//    Same edge: ack[w]<=1, grant_id<=w, busy<=1, go to START.
//  - START: tx_start=1 for this single cycle, ack back to 0, go to WAIT_DONE.
//  - WAIT_DONE: hold tx_data. On tx_done: ptr<=grant_id, busy<=0, go to IDLE.
//  - Latency: req rises in IDLE -> ack next edge -> tx_start one cycle later.
//    Minimum gap tx_done -> next tx_start is 2 cycles.
//  - tx_done in IDLE or START is ignored. req changes outside IDLE have no effect.
//  - Single active requester is re-granted every byte. No starvation: each requester waits at most NREQ-1 bytes.
//  - Requester may change req_data or drop req the cycle after its ack.
//  - Async reset mid-transfer: FSM to IDLE, outputs to reset values, byte in flight lost.
//    The Transmitter is reset by the same reset.
// CONFIGURATION
//  - Macro UART_TX_ARB_BURST_EN.
//  - Defined: in WAIT_DONE on tx_done, if req[grant_id]=1 and burst_cnt < MAX_BURST-1:
//    re-grant the same requester directly (ack, latch, go to START); ptr is not updated; burst_cnt++.
//    Otherwise burst_cnt<=0 and normal rotation applies.
//  - Undefined: no burst counter; strict per-byte rotation.
// STRUCTURE
//  - Package uart_pkg: DBITS default, FSM state localparams (IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2).
//  - Sub-module uart_rr_picker: combinational rotate-priority encoder. Inputs req, ptr; outputs valid, winner.
// TESTING
//  - Reset: reset high then low; no req -> tx_start never asserts, busy=0, grant_id=0.
//  - Single: req[2]=1, byte 0x41 -> ack[2] next edge, tx_start with tx_data=0x41.
//    Model tx_done after 100 cycles -> busy=0.
//  - Contention, no macro: req=4'b1111, bytes 0xA0..0xA3 held.
//    Grant order 0,1,2,3,0; each ack aligns with the matching byte on tx_data.
//  - Burst, macro defined: req=4'b0011 held, MAX_BURST=4 -> grant order 0,0,0,0,1,1,1,1,0.
//  - Reset mid-op: reset asserted in WAIT_DONE -> tx_start=0, busy=0 immediately.
//    After release, req[1]=1 -> requester 1 granted.
//  - Stray tx_done: pulse in IDLE and in START -> state unchanged; the real transfer completes only on a later tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose : shared types and defaults for the UART transmit arbiter slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents: default data width and the arbiter FSM state encoding.
package uart_pkg;

  // Data bits per byte; must match the Transmitter's DBITS.
  localparam int DBITS_DEF = 8;

  // Arbiter FSM states. Encodings are fixed so waveforms read the same
  // across builds.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_rr_picker.sv
// Purpose : rotate-priority encoder; picks the first requester at or after (ptr+1) mod NREQ.
// Latency : purely combinational, zero cycles.
// Backpr. : none; the caller decides when to consume the pick.
//
// Ports:
//   req    in  NREQ          request vector
//   ptr    in  clog2(NREQ)   index of the last requester served
//   valid  out 1             at least one request is present
//   winner out clog2(NREQ)   index of the chosen requester (0 when !valid)
module uart_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0] idx;

  // Walk the candidates from farthest to nearest so the nearest
  // requester after ptr is the last assignment and therefore wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule : uart_rr_picker

// File: rtl/uart_tx_arbiter.sv
// Purpose : shares one UART Transmitter among NREQ byte requesters, round-robin per byte.
// Latency : req in IDLE -> ack next edge -> tx_start one cycle later; tx_done -> next tx_start >= 2 idle cycles.
// Backpr. : requesters hold req/data until ack; the Transmitter throttles us through tx_done.
//
// Ports:
//   clk       in  1            system clock
//   reset     in  1            asynchronous active-high reset
//   req       in  NREQ         level request per requester
//   req_data  in  NREQ*DBITS   byte of requester i on [i*DBITS +: DBITS]
//   ack       out NREQ         one-cycle pulse: byte of requester i latched
//   tx_start  out 1            one-cycle start pulse to the Transmitter
//   tx_data   out DBITS        byte to Transmitter, stable from tx_start until tx_done
//   tx_done   in  1            one-cycle completion pulse from the Transmitter
//   busy      out 1            high from grant until tx_done is consumed
//   grant_id  out clog2(NREQ)  index of the current/last grant
//
// Build option: define UART_TX_ARB_BURST_EN to let a requester that still
// has req high keep the Transmitter for up to MAX_BURST consecutive bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DBITS     = DBITS_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBITS-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [DBITS-1:0]        tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int GW = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic [DBITS-1:0]  tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic [GW-1:0]     grant_q, grant_d;

  logic              pick_vld;
  logic [GW-1:0]     pick_id;

  // Unpacked view of the flat request-data bus, one byte per requester.
  logic [DBITS-1:0]  req_byte [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_req_byte
    assign req_byte[i] = req_data[i*DBITS +: DBITS];
  end

`ifdef UART_TX_ARB_BURST_EN
  // Counts re-grants of the current owner; 0..MAX_BURST-1.
  localparam int BCW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  logic [BCW-1:0]    burst_q, burst_d;
`else
  // Burst length is meaningless when bursting is compiled out.
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
`endif

  uart_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .winner (pick_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= GW'(NREQ - 1);  // requester 0 wins the first arbitration
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
`ifdef UART_TX_ARB_BURST_EN
      burst_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
`ifdef UART_TX_ARB_BURST_EN
      burst_q    <= burst_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ack_d      = '0;     // ack and tx_start are single-cycle pulses
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
`ifdef UART_TX_ARB_BURST_EN
    burst_d    = burst_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          tx_data_d      = req_byte[pick_id];
          ack_d[pick_id] = 1'b1;
          grant_d        = pick_id;
          busy_d         = 1'b1;
          state_d        = START;
        end
      end

      // ack is visible during this cycle; tx_start follows one cycle later
      // so the Transmitter sees a byte that has already settled. tx_done
      // arriving here cannot belong to our byte and is dropped.
      START: begin
        tx_start_d = 1'b1;
        state_d    = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (tx_done) begin
`ifdef UART_TX_ARB_BURST_EN
          if (req[grant_q] && (burst_q < BURST_LAST)) begin
            // Owner keeps the line; ptr stays put so rotation resumes
            // from the same place once the burst ends.
            ack_d[grant_q] = 1'b1;
            tx_data_d      = req_byte[grant_q];
            burst_d        = burst_q + BCW'(1);
            state_d        = START;
          end else begin
            burst_d = '0;
            ptr_d   = grant_q;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          ptr_d   = grant_q;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter with a queue-free reference model.
// Latency : n/a.
// Backpr. : the bench plays the Transmitter and answers each tx_start with a delayed tx_done.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int DBITS     = 8;
  localparam int MAX_BURST = 4;
  localparam int GW        = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*DBITS-1:0] req_data;
  logic                  tx_done;
  logic [NREQ-1:0]       ack;
  logic                  tx_start;
  logic [DBITS-1:0]      tx_data;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last served requester, forced re-grant, burst count.
  int m_ptr   = NREQ - 1;
  int m_force = -1;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .DBITS     (DBITS),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_ptr   = NREQ - 1;
    m_force = -1;
    m_cnt   = 0;
  endfunction

  // Next owner: lowest active index above the last served one, else the
  // lowest active index overall (wrap-around).
  function automatic int model_pick();
    int lowest;
    int above;
    lowest = -1;
    above  = -1;
    if (m_force >= 0) return m_force;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (lowest < 0) lowest = i;
        if (above < 0 && i > m_ptr) above = i;
      end
    end
    return (above >= 0) ? above : lowest;
  endfunction

  function automatic void model_done(input int w);
`ifdef UART_TX_ARB_BURST_EN
    if (req[w] && m_cnt < MAX_BURST - 1) begin
      m_force = w;
      m_cnt   = m_cnt + 1;
    end else begin
      m_force = -1;
      m_cnt   = 0;
      m_ptr   = w;
    end
`else
    m_force = -1;
    m_ptr   = w;
`endif
  endfunction

  // One full byte: wait for ack, check the grant, play the Transmitter.
  // mode 0: hold requests, 1: random churn after ack, 2: drop all after ack.
  task automatic do_byte(input int mode, output int g);
    int               w;
    int               waited;
    int               lat;
    int               exp_wait;
    logic [NREQ-1:0]  exp_ack;
    logic [NREQ-1:0]  old_req;
    logic [NREQ-1:0]  nr;
    logic [DBITS-1:0] exp_b;
    logic             exp_busy;
    w        = model_pick();
    exp_wait = (m_force >= 0) ? 0 : 1;
    exp_b    = req_data[w*DBITS +: DBITS];
    exp_ack  = '0;
    exp_ack[w] = 1'b1;
    waited   = 0;
    while (ack == '0 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (ack !== exp_ack) begin
      n_fail++; $display("FAIL byte_ack: got %b want %b", ack, exp_ack);
    end
    n_checks++;
    if (waited != exp_wait) begin
      n_fail++; $display("FAIL ack_latency: got %0d want %0d", waited, exp_wait);
    end
    n_checks++;
    if (grant_id !== GW'(w)) begin
      n_fail++; $display("FAIL byte_grant_id: got %0d want %0d", grant_id, w);
    end
    n_checks++;
    if (tx_data !== exp_b || busy !== 1'b1) begin
      n_fail++; $display("FAIL byte_latch: got data %h busy %b want %h 1", tx_data, busy, exp_b);
    end
    if (mode == 1) begin
      old_req = req;
      nr = (old_req & ~exp_ack) | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (nr == '0) nr[$urandom_range(0, NREQ - 1)] = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (i == w || !old_req[i]) req_data[i*DBITS +: DBITS] = DBITS'($urandom);
      req = nr;
    end else if (mode == 2) begin
      req = '0;
    end
    tick();
    n_checks++;
    if (tx_start !== 1'b1 || ack !== '0 || tx_data !== exp_b) begin
      n_fail++; $display("FAIL byte_start: got start %b ack %b data %h want 1 0 %h", tx_start, ack, tx_data, exp_b);
    end
    lat = $urandom_range(1, 15);
    repeat (lat) tick();
    n_checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== exp_b) begin
      n_fail++; $display("FAIL byte_wait: got start %b busy %b data %h want 0 1 %h", tx_start, busy, tx_data, exp_b);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    model_done(w);
    exp_busy = (m_force >= 0);
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++; $display("FAIL byte_done_busy: got %b want %b", busy, exp_busy);
    end
    g = w;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
    tick(); tick();
    n_checks++;
    if (ack !== '0 || tx_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got ack %b start %b busy %b want 0 0 0", ack, tx_start, busy);
    end
    n_checks++;
    if (tx_data !== '0 || grant_id !== '0) begin
      n_fail++; $display("FAIL reset_data: got data %h gid %0d want 0 0", tx_data, grant_id);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (tx_start !== 1'b0 || busy !== 1'b0 || grant_id !== '0) begin
        n_fail++; $display("FAIL reset_idle: got start %b busy %b gid %0d want 0 0 0", tx_start, busy, grant_id);
      end
    end
  endtask

  task automatic test_single();
    req_data[2*DBITS +: DBITS] = 8'h41;
    req = 4'b0100;
    tick();
    n_checks++;
    if (ack !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1 || tx_start !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: got ack %b gid %0d busy %b start %b want 0100 2 1 0", ack, grant_id, busy, tx_start);
    end
    req = '0;
    tick();
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h41 || ack !== '0) begin
      n_fail++; $display("FAIL single_start: got start %b data %h ack %b want 1 41 0", tx_start, tx_data, ack);
    end
    repeat (100) tick();
    n_checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h41) begin
      n_fail++; $display("FAIL single_hold: got busy %b start %b data %h want 1 0 41", busy, tx_start, tx_data);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    model_done(2);
    n_checks++;
    if (busy !== 1'b0 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_done: got busy %b gid %0d want 0 2", busy, grant_id);
    end
  endtask

  task automatic test_stray_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || ack !== '0 || tx_start !== 1'b0) begin
      n_fail++; $display("FAIL stray_idle: got busy %b ack %b start %b want 0 0 0", busy, ack, tx_start);
    end
    req_data[3*DBITS +: DBITS] = 8'h7E;
    req = 4'b1000;
    tick();
    n_checks++;
    if (ack !== 4'b1000 || grant_id !== 2'd3) begin
      n_fail++; $display("FAIL stray_ack: got ack %b gid %0d want 1000 3", ack, grant_id);
    end
    req = '0;
    tx_done = 1'b1;  // lands while the arbiter is in START
    tick();
    tx_done = 1'b0;
    n_checks++;
    if (tx_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stray_start: got start %b busy %b want 1 1", tx_start, busy);
    end
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b1 || tx_data !== 8'h7E) begin
      n_fail++; $display("FAIL stray_hold: got busy %b data %h want 1 7e", busy, tx_data);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    model_done(3);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_done: got busy %b want 0", busy);
    end
  endtask

  task automatic test_contention();
    int g;
`ifdef UART_TX_ARB_BURST_EN
    int exp_ord [5] = '{0, 0, 0, 0, 1};
`else
    int exp_ord [5] = '{0, 1, 2, 3, 0};
`endif
    pulse_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DBITS +: DBITS] = DBITS'(8'hA0 + i);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      do_byte((n == 4) ? 2 : 0, g);
      n_checks++;
      if (g != exp_ord[n]) begin
        n_fail++; $display("FAIL contention_order[%0d]: got %0d want %0d", n, g, exp_ord[n]);
      end
    end
  endtask

`ifdef UART_TX_ARB_BURST_EN
  task automatic test_burst();
    int g;
    int exp_ord [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    pulse_reset();
    req_data[0 +: DBITS]     = 8'hB0;
    req_data[DBITS +: DBITS] = 8'hB1;
    req = 4'b0011;
    for (int n = 0; n < 9; n++) begin
      do_byte((n == 8) ? 2 : 0, g);
      n_checks++;
      if (g != exp_ord[n]) begin
        n_fail++; $display("FAIL burst_order[%0d]: got %0d want %0d", n, g, exp_ord[n]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int g;
    for (int i = 0; i < NREQ; i++) req_data[i*DBITS +: DBITS] = DBITS'($urandom);
    req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    for (int n = 0; n < 40; n++) do_byte((n == 39) ? 2 : 1, g);
  endtask

  task automatic test_reset_mid();
    int g;
    req_data[3*DBITS +: DBITS] = 8'h5A;
    req = 4'b1000;
    tick();
    n_checks++;
    if (ack !== 4'b1000) begin
      n_fail++; $display("FAIL mid_ack: got %b want 1000", ack);
    end
    req = '0;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got start %b busy %b ack %b want 0 0 0", tx_start, busy, ack);
    end
    n_checks++;
    if (grant_id !== '0 || tx_data !== '0) begin
      n_fail++; $display("FAIL mid_reset_data: got gid %0d data %h want 0 0", grant_id, tx_data);
    end
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    req_data[DBITS +: DBITS] = 8'hC3;
    req = 4'b0010;
    do_byte(2, g);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stray_done();
    test_contention();
`ifdef UART_TX_ARB_BURST_EN
    test_burst();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_arbiter
